// File: rtl/ram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// ram_fifo_ctrl
//   Streaming FIFO controller that sits directly upstream of a dual-address RAM
//   with a registered read port (1 posedge latency) and a negedge write port.
//   The controller owns the RAM addresses and the rd_en / wr_en / cs strobes,
//   and presents a valid/ready interface on both sides. The RAM output register
//   is used as one extra holding slot, so the FIFO stores DEPTH+1 words.
//
//   Optional feature macro: FALLTHROUGH_EN
//     When defined, a word pushed into an empty RAM is fetched in the same
//     cycle (the negedge write lands before the posedge read), which cuts
//     push-to-out_valid latency from 2 cycles to 1.
//
// Ports
//   clk             in   1          clock, all state on posedge
//   rst             in   1          asynchronous active-high reset
//   flush           in   1          synchronous clear of all FIFO state
//   in_valid        in   1          producer has a word
//   in_ready        out  1          controller accepts a word this cycle
//   in_data         in   WORDSIZE   producer word
//   out_valid       out  1          out_data holds a valid word
//   out_ready       in   1          consumer takes out_data this cycle
//   out_data        out  WORDSIZE   word at the head of the FIFO (RAM output)
//   ram_read_addr   out  ADDRSIZE   RAM read address
//   ram_write_addr  out  ADDRSIZE   RAM write address
//   ram_rd_en       out  1          RAM read enable
//   ram_wr_en       out  1          RAM write enable
//   ram_cs          out  1          RAM chip select
//   ram_data_in     out  WORDSIZE   RAM write data
//   ram_data_out    in   WORDSIZE   RAM registered read data
//   count           out  ADDRSIZE+1 occupancy, 0..DEPTH+1
// -----------------------------------------------------------------------------
module ram_fifo_ctrl #(
   parameter int WORDSIZE = 16,
   parameter int ADDRSIZE = 6
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WORDSIZE-1:0] in_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [WORDSIZE-1:0] out_data,
   output logic [ADDRSIZE-1:0] ram_read_addr,
   output logic [ADDRSIZE-1:0] ram_write_addr,
   output logic                ram_rd_en,
   output logic                ram_wr_en,
   output logic                ram_cs,
   output logic [WORDSIZE-1:0] ram_data_in,
   input  logic [WORDSIZE-1:0] ram_data_out,
   output logic [ADDRSIZE:0]   count
);

   localparam logic [ADDRSIZE:0]   DEPTH_C   = {1'b1, {ADDRSIZE{1'b0}}};
   localparam logic [ADDRSIZE:0]   CNT_ZERO_C = {(ADDRSIZE+1){1'b0}};
   localparam logic [ADDRSIZE:0]   CNT_ONE_C = {{ADDRSIZE{1'b0}}, 1'b1};
   localparam logic [ADDRSIZE-1:0] PTR_ZERO_C = {ADDRSIZE{1'b0}};
   localparam logic [ADDRSIZE-1:0] PTR_ONE_C = {{(ADDRSIZE-1){1'b0}}, 1'b1};

   // Output stage: EMPTY when the RAM output register holds nothing useful,
   // HOLD when it holds the head word of the FIFO.
   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_HOLD  = 1'b1
   } out_state_t;

   out_state_t          out_state_r;
   logic [ADDRSIZE-1:0] wr_ptr_r;
   logic [ADDRSIZE-1:0] rd_ptr_r;
   logic [ADDRSIZE:0]   ram_cnt_r;

   logic out_valid_s;
   logic in_ready_s;
   logic push_s;
   logic avail_s;
   logic fetch_s;
   logic pop_s;

   // Handshake decode: push, fetch (RAM read into the output register) and pop
   always_comb begin
      out_valid_s = (out_state_r == ST_HOLD);
      // A full RAM refuses pushes even when a pop frees the output slot this
      // cycle; the freed slot only propagates back once the fetch lands.
      in_ready_s  = (ram_cnt_r != DEPTH_C) && !rst;
      push_s      = in_valid && in_ready_s && !flush;
`ifdef FALLTHROUGH_EN
      // The negedge write of the pushed word precedes the posedge read, so an
      // empty RAM can hand the word straight through in the same cycle.
      avail_s     = (ram_cnt_r != CNT_ZERO_C) || push_s;
`else
      avail_s     = (ram_cnt_r != CNT_ZERO_C);
`endif
      // Refill the output register whenever it is empty or being drained.
      fetch_s     = avail_s && (!out_valid_s || out_ready) && !rst && !flush;
      pop_s       = out_valid_s && out_ready;
   end

   // RAM interface and status outputs
   always_comb begin
      in_ready       = in_ready_s;
      out_valid      = out_valid_s;
      out_data       = ram_data_out;
      ram_cs         = !rst;
      ram_wr_en      = push_s;
      ram_rd_en      = fetch_s;
      ram_write_addr = wr_ptr_r;
      ram_read_addr  = rd_ptr_r;
      ram_data_in    = in_data;
      if (rst) begin
         count = CNT_ZERO_C;
      end else begin
         count = ram_cnt_r + {{ADDRSIZE{1'b0}}, out_valid_s};
      end
   end

   // FIFO state: pointers, RAM occupancy and output-stage FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r    <= PTR_ZERO_C;
         rd_ptr_r    <= PTR_ZERO_C;
         ram_cnt_r   <= CNT_ZERO_C;
         out_state_r <= ST_EMPTY;
      end else if (flush) begin
         wr_ptr_r    <= PTR_ZERO_C;
         rd_ptr_r    <= PTR_ZERO_C;
         ram_cnt_r   <= CNT_ZERO_C;
         out_state_r <= ST_EMPTY;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end

         if (fetch_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end

         case ({push_s, fetch_s})
            2'b10:   ram_cnt_r <= ram_cnt_r + CNT_ONE_C;
            2'b01:   ram_cnt_r <= ram_cnt_r - CNT_ONE_C;
            default: ram_cnt_r <= ram_cnt_r;
         endcase

         case (out_state_r)
            ST_EMPTY: begin
               if (fetch_s) begin
                  out_state_r <= ST_HOLD;
               end else begin
                  out_state_r <= ST_EMPTY;
               end
            end
            ST_HOLD: begin
               // A fetch while holding implies out_ready, so pop and refill
               // together keep the stage full at one word per cycle.
               if (fetch_s) begin
                  out_state_r <= ST_HOLD;
               end else if (pop_s) begin
                  out_state_r <= ST_EMPTY;
               end else begin
                  out_state_r <= ST_HOLD;
               end
            end
            default: out_state_r <= ST_EMPTY;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ram_fifo_ctrl
//   Self-checking bench for ram_fifo_ctrl with a behavioural dual-address RAM
//   (negedge write, registered posedge read). Inputs are driven 1 time unit
//   after posedge, outputs are sampled on negedge.
// -----------------------------------------------------------------------------
module tb_ram_fifo_ctrl;

   localparam int WS    = 16;
   localparam int AS    = 6;
   localparam int DEPTH = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [WS-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [WS-1:0] out_data;
   logic [AS-1:0] ram_read_addr;
   logic [AS-1:0] ram_write_addr;
   logic          ram_rd_en;
   logic          ram_wr_en;
   logic          ram_cs;
   logic [WS-1:0] ram_data_in;
   logic [WS-1:0] ram_data_out;
   logic [AS:0]   count;

   int checks = 0;
   int errors = 0;

   logic [WS-1:0] mem [DEPTH];
   logic [WS-1:0] q [$];

   always #5 clk = ~clk;

   ram_fifo_ctrl #(.WORDSIZE(WS), .ADDRSIZE(AS)) dut (
      .clk            (clk),
      .rst            (rst),
      .flush          (flush),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_data        (in_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .ram_read_addr  (ram_read_addr),
      .ram_write_addr (ram_write_addr),
      .ram_rd_en      (ram_rd_en),
      .ram_wr_en      (ram_wr_en),
      .ram_cs         (ram_cs),
      .ram_data_in    (ram_data_in),
      .ram_data_out   (ram_data_out),
      .count          (count)
   );

   // Behavioural RAM: write on negedge, registered read on posedge
   always @(negedge clk) begin
      if (ram_cs && ram_wr_en) mem[ram_write_addr] <= ram_data_in;
   end

   always @(posedge clk) begin
      if (ram_cs && ram_rd_en) ram_data_out <= mem[ram_read_addr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One cycle: drive after posedge, return at the following negedge
   task automatic cyc(input logic iv, input logic [WS-1:0] d, input logic ordy);
      @(posedge clk);
      #1;
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      @(negedge clk);
   endtask

   // One cycle with scoreboard: occupancy, pop order, push capture
   task automatic sb_cycle(input logic iv, input logic [WS-1:0] d, input logic ordy,
                           output logic acc);
      logic [WS-1:0] exp;
      cyc(iv, d, ordy);
      check("count_vs_queue", 32'(count), 32'(q.size()));
      if (out_valid && out_ready) begin
         if (q.size() == 0) begin
            check("pop_on_empty", 32'(out_valid), 32'd0);
         end else begin
            exp = q.pop_front();
            check("pop_data", 32'(out_data), 32'(exp));
         end
      end
      acc = in_valid && in_ready;
      if (acc) q.push_back(d);
   endtask

   task automatic do_flush();
      @(posedge clk);
      #1;
      flush     = 1'b1;
      in_valid  = 1'b1;
      in_data   = 16'hDEAD;
      out_ready = 1'b1;
      @(negedge clk);
      check("flush_wr_en", 32'(ram_wr_en), 32'd0);
      check("flush_rd_en", 32'(ram_rd_en), 32'd0);
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("flush_count", 32'(count), 32'd0);
      check("flush_out_valid", 32'(out_valid), 32'd0);
      q.delete();
   endtask

   task automatic drain();
      logic acc;
      for (int i = 0; i < 300; i++) begin
         if (q.size() == 0 && !out_valid) break;
         sb_cycle(1'b0, 16'h0000, 1'b1, acc);
      end
      check("drain_count", 32'(count), 32'd0);
      check("drain_out_valid", 32'(out_valid), 32'd0);
   endtask

   task automatic fill10();
      logic acc;
      do_flush();
      for (int i = 0; i < 10; i++) sb_cycle(1'b1, 16'(16'hA000 + i), 1'b0, acc);
      sb_cycle(1'b0, 16'h0000, 1'b0, acc);
      check("fill_count", 32'(count), 32'd10);
   endtask

   task automatic push_expect(input string tag, input logic [WS-1:0] w);
      logic acc;
      sb_cycle(1'b1, w, 1'b0, acc);
      check({tag, "_accept"}, 32'(acc), 32'd1);
      for (int i = 0; i < 5 && !out_valid; i++) sb_cycle(1'b0, 16'h0000, 1'b0, acc);
      check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_out_data"}, 32'(out_data), 32'(w));
      drain();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int  nxt;
      int  pops;
      logic acc;

      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 16'h0000;
      out_ready = 1'b0;

      // Reset state, with a push attempt pending
      cyc(1'b1, 16'h5555, 1'b1);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_cs", 32'(ram_cs), 32'd0);
      check("rst_rd_en", 32'(ram_rd_en), 32'd0);
      check("rst_wr_en", 32'(ram_wr_en), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      rst      = 1'b0;
      in_valid = 1'b0;

      // Test 1: single push, latency and data
      cyc(1'b1, 16'h1234, 1'b0);
      check("t1_cs", 32'(ram_cs), 32'd1);
      check("t1_in_ready", 32'(in_ready), 32'd1);
      check("t1_wr_en", 32'(ram_wr_en), 32'd1);
      check("t1_wr_addr", 32'(ram_write_addr), 32'd0);
      check("t1_data_in", 32'(ram_data_in), 32'h1234);
      check("t1_count0", 32'(count), 32'd0);
`ifdef FALLTHROUGH_EN
      check("t1_ft_rd_en", 32'(ram_rd_en), 32'd1);
      check("t1_ft_rd_addr", 32'(ram_read_addr), 32'd0);
      cyc(1'b0, 16'h0000, 1'b0);
`else
      check("t1_rd_en0", 32'(ram_rd_en), 32'd0);
      cyc(1'b0, 16'h0000, 1'b0);
      check("t1_valid_early", 32'(out_valid), 32'd0);
      check("t1_rd_en1", 32'(ram_rd_en), 32'd1);
      check("t1_count1", 32'(count), 32'd1);
      cyc(1'b0, 16'h0000, 1'b0);
`endif
      check("t1_out_valid", 32'(out_valid), 32'd1);
      check("t1_out_data", 32'(out_data), 32'h1234);
      check("t1_count", 32'(count), 32'd1);
      check("t1_hold_rd_en", 32'(ram_rd_en), 32'd0);

      // Test 2: fill with out_ready low, 65 accepts then backpressure
      do_flush();
      nxt = 0;
      for (int c = 0; c < 80; c++) begin
         sb_cycle(1'b1, 16'(nxt), 1'b0, acc);
         if (acc) nxt++;
      end
      check("t2_accepts", 32'(nxt), 32'd65);
      check("t2_count", 32'(count), 32'd65);
      check("t2_in_ready", 32'(in_ready), 32'd0);
      check("t2_out_data", 32'(out_data), 32'd0);

      // Test 3: drain from full while pushing; pushes resume one cycle later
      sb_cycle(1'b1, 16'(nxt), 1'b1, acc);
      check("t3_first_refused", 32'(acc), 32'd0);
      sb_cycle(1'b1, 16'(nxt), 1'b1, acc);
      check("t3_resume", 32'(acc), 32'd1);
      if (acc) nxt++;
      for (int c = 0; c < 68; c++) begin
         sb_cycle(1'b1, 16'(nxt), 1'b1, acc);
         check("t3_out_valid", 32'(out_valid), 32'd1);
         if (acc) nxt++;
      end
      drain();

      // Test 4: 200-word stream across pointer wrap, full throughput
      pops = 0;
      for (int c = 0; c < 200; c++) begin
         sb_cycle(1'b1, 16'(nxt), 1'b1, acc);
         if (acc) nxt++;
         if (c >= 4 && out_valid) pops++;
      end
      check("t4_throughput", 32'(pops), 32'd196);
      drain();

      // Test 5: random valid/ready against the scoreboard
      for (int c = 0; c < 10000; c++) begin
         sb_cycle(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)), acc);
      end
      drain();

      // Test 6a: flush with 10 words, then 0xBEEF is first out
      fill10();
      do_flush();
      push_expect("t6_flush", 16'hBEEF);

      // Test 6b: one-cycle reset with 10 words, then 0xBEEF is first out
      fill10();
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("t6_rst_count", 32'(count), 32'd0);
      check("t6_rst_out_valid", 32'(out_valid), 32'd0);
      check("t6_rst_in_ready", 32'(in_ready), 32'd0);
      check("t6_rst_cs", 32'(ram_cs), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      q.delete();
      push_expect("t6_rst", 16'hBEEF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
